// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit shift-register sequencer.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SEND,
    DONE
  } tx_ctrl_state_t;

  localparam int BYTE_BITS = 8;
  localparam int BIT_CNT_W = $clog2(BYTE_BITS);

  // States in which the holding register may take a new byte.
  function automatic logic accepts_bytes(input tx_ctrl_state_t s);
    return (s == PRIME) || (s == SEND);
  endfunction

endpackage

// File: rtl/usb_tx_shift_ctrl_if.sv
// Byte stream from the packet/encryption pipeline into the transmit sequencer.
interface usb_tx_shift_ctrl_if;

  logic                           byte_valid;
  logic [usb_tx_pkg::BYTE_BITS-1:0] byte_data;
  logic                           byte_last;
  logic                           byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  byte_last,
    output byte_ready
  );

endinterface

// File: rtl/usb_bit_timer.sv
// Modulo-CLKS_PER_BIT bit-time counter with synchronous clear and a rollover
// flag that is high during the last clock of each bit time.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic rollover
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(CLKS_PER_BIT - 1);

  logic [TIMER_W-1:0] count_reg;
  logic [TIMER_W-1:0] count_next;

  always_comb begin
    count_next = count_reg + TIMER_W'(1);
    if (clear || (count_reg == LAST_COUNT)) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign rollover = !clear && (count_reg == LAST_COUNT);

endmodule

// File: rtl/usb_tx_shift_ctrl.sv
// Sequencing controller for the USB transmit shift register: one-byte holding
// register, fixed-rate load/shift strobes, completion and underrun reporting.
module usb_tx_shift_ctrl
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tx_start,
  usb_tx_shift_ctrl_if.slave    byte_if,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [BYTE_BITS-1:0]  pts_data,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  underrun
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_BITS - 1);

  tx_ctrl_state_t       state_reg;
  logic [BYTE_BITS-1:0] hold_data_reg;
  logic                 hold_last_reg;
  logic                 hold_full_reg;
  logic                 last_accepted_reg;
  logic                 cur_last_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [BYTE_BITS-1:0] pts_data_reg;
  logic                 load_enable_reg;
  logic                 shift_enable_reg;
  logic                 busy_reg;
  logic                 tx_done_reg;
  logic                 underrun_reg;

  logic byte_ready_int;
  logic xfer;
  logic timer_clear;
  logic timer_rollover;
  logic bit_boundary;

  // The timer only runs while bits are on the wire; it restarts from zero on
  // the first load so every byte gets exactly CLKS_PER_BIT clocks per bit.
  assign timer_clear = (state_reg != SEND);

  usb_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (timer_clear),
    .rollover (timer_rollover)
  );

  assign bit_boundary   = (state_reg == SEND) && timer_rollover;
  assign byte_ready_int = accepts_bytes(state_reg) && !hold_full_reg && !last_accepted_reg;
  assign xfer           = byte_if.byte_valid && byte_ready_int;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg         <= IDLE;
      hold_data_reg     <= '0;
      hold_last_reg     <= 1'b0;
      hold_full_reg     <= 1'b0;
      last_accepted_reg <= 1'b0;
      cur_last_reg      <= 1'b0;
      bit_cnt_reg       <= '0;
      pts_data_reg      <= '0;
      load_enable_reg   <= 1'b0;
      shift_enable_reg  <= 1'b0;
      busy_reg          <= 1'b0;
      tx_done_reg       <= 1'b0;
      underrun_reg      <= 1'b0;
    end else begin
      load_enable_reg  <= 1'b0;
      shift_enable_reg <= 1'b0;
      tx_done_reg      <= 1'b0;
      underrun_reg     <= 1'b0;
      busy_reg         <= (state_reg != IDLE);

      if (xfer) begin
        hold_data_reg <= byte_if.byte_data;
        hold_last_reg <= byte_if.byte_last;
        hold_full_reg <= 1'b1;
        if (byte_if.byte_last) begin
          last_accepted_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (tx_start) begin
            state_reg <= PRIME;
          end
        end

        PRIME: begin
          if (hold_full_reg) begin
            load_enable_reg <= 1'b1;
            pts_data_reg    <= hold_data_reg;
            hold_full_reg   <= xfer;
            cur_last_reg    <= hold_last_reg;
            bit_cnt_reg     <= '0;
            state_reg       <= SEND;
          end
        end

        SEND: begin
          if (bit_boundary) begin
            if (bit_cnt_reg != LAST_BIT) begin
              shift_enable_reg <= 1'b1;
              bit_cnt_reg      <= bit_cnt_reg + BIT_CNT_W'(1);
            end else if (cur_last_reg) begin
              state_reg <= DONE;
            end else if (hold_full_reg) begin
              // A byte arriving at this same edge lands in the holding
              // register after the held byte has been handed over.
              load_enable_reg <= 1'b1;
              pts_data_reg    <= hold_data_reg;
              hold_full_reg   <= xfer;
              cur_last_reg    <= hold_last_reg;
              bit_cnt_reg     <= '0;
            end else begin
              // Too late for this boundary: a byte captured now is dropped.
              underrun_reg      <= 1'b1;
              hold_full_reg     <= 1'b0;
              last_accepted_reg <= 1'b0;
              state_reg         <= IDLE;
            end
          end
        end

        DONE: begin
          tx_done_reg       <= 1'b1;
          last_accepted_reg <= 1'b0;
          state_reg         <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign byte_if.byte_ready = byte_ready_int;
  assign load_enable        = load_enable_reg;
  assign shift_enable       = shift_enable_reg;
  assign pts_data           = pts_data_reg;
  assign busy               = busy_reg;
  assign tx_done            = tx_done_reg;
  assign underrun           = underrun_reg;

endmodule

// File: tb/tb_usb_tx_shift_ctrl.sv
`timescale 1ns/1ps
// Random packet traffic checked against a per-packet schedule computed from the
// byte offer times: load/shift/done/underrun cycles, ready windows and serial bits.
module tb_usb_tx_shift_ctrl;

  localparam int C      = 8;
  localparam int BYTE_T = 8 * C;

  logic       clk      = 1'b0;
  logic       n_rst    = 1'b0;
  logic       tx_start = 1'b0;
  logic       load_enable;
  logic       shift_enable;
  logic [7:0] pts_data;
  logic       busy;
  logic       tx_done;
  logic       underrun;

  usb_tx_shift_ctrl_if byte_if ();

  usb_tx_shift_ctrl #(
    .CLKS_PER_BIT (C)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .byte_if      (byte_if),
    .load_enable  (load_enable),
    .shift_enable (shift_enable),
    .pts_data     (pts_data),
    .busy         (busy),
    .tx_done      (tx_done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         pkt_id = 0;
  logic [7:0] pts_sr  = 8'h00;
  logic [7:0] exp_pts = 8'h00;

  logic [7:0] pkt_data [8];
  int         pkt_gap  [8];
  int         offer    [8];
  int         acc      [8];
  int         load_at  [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // Advance one clock; a downstream shift register follows the strobes.
  task automatic step();
    logic       le;
    logic       se;
    logic [7:0] pd;
    le = load_enable;
    se = shift_enable;
    pd = pts_data;
    @(posedge clk);
    cyc++;
    if (le) pts_sr = pd;
    else if (se) pts_sr = {1'b0, pts_sr[7:1]};
    #1;
  endtask

  task automatic check_quiet(input string where);
    check_eq({where, "_load"},  32'(load_enable),        32'd0);
    check_eq({where, "_shift"}, 32'(shift_enable),       32'd0);
    check_eq({where, "_busy"},  32'(busy),               32'd0);
    check_eq({where, "_done"},  32'(tx_done),            32'd0);
    check_eq({where, "_under"}, 32'(underrun),           32'd0);
    check_eq({where, "_ready"}, 32'(byte_if.byte_ready), 32'd0);
    check_eq({where, "_pts"},   32'(pts_data),           32'(exp_pts));
  endtask

  task automatic apply_reset();
    tx_start           = 1'b0;
    byte_if.byte_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    exp_pts = 8'h00;
    check_quiet("rst");
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tx_start           = 1'b0;
      byte_if.byte_valid = 1'($urandom_range(0, 1));
      byte_if.byte_data  = 8'($urandom);
      byte_if.byte_last  = 1'($urandom_range(0, 1));
      step();
      check_quiet("idle");
    end
  endtask

  task automatic run_packet(input int n, input bit do_abort, input bit stray,
                            input bit keep_valid, output bit was_underrun);
    int    t0, nl, ns, u, end_busy, stray_c, abort_c, hi, k;
    bit    completed, aborted, e_load, e_shift, e_ready;
    string result;

    // Schedule: acceptance edges, load cycles and the underrun point.
    t0 = cyc + 1;
    u  = -1;
    nl = 0;
    ns = 0;
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0)                offer[i] = t0 + pkt_gap[i];
      else if (pkt_gap[i] == -1) offer[i] = load_at[i-1] + BYTE_T;
      else if (pkt_gap[i] == -2) offer[i] = load_at[i-1] + BYTE_T - 1;
      else                       offer[i] = acc[i-1] + 1 + pkt_gap[i];
      if (i == 0) acc[i] = (offer[i] > t0 + 1) ? offer[i] : t0 + 1;
      else        acc[i] = (offer[i] > load_at[i-1] + 1) ? offer[i] : load_at[i-1] + 1;
      ns++;
      if (i > 0 && acc[i] >= load_at[i-1] + BYTE_T) begin
        u = load_at[i-1] + BYTE_T;
        break;
      end
      load_at[i] = (i == 0) ? acc[0] + 1 : load_at[i-1] + BYTE_T;
      nl++;
    end
    completed = (u < 0);
    end_busy  = completed ? load_at[nl-1] + BYTE_T + 1 : u;
    stray_c   = load_at[0] + int'($urandom_range(0, 40));
    abort_c   = (nl > 1) ? load_at[1] + 3 * C + 3 : -10;

    while (cyc <= end_busy + 1 && !aborted) begin
      tx_start           = (cyc == t0 - 1) || (stray && cyc == stray_c);
      byte_if.byte_valid = 1'b0;
      byte_if.byte_data  = 8'($urandom);
      byte_if.byte_last  = 1'($urandom_range(0, 1));
      if (keep_valid && completed && cyc >= acc[n-1]) byte_if.byte_valid = 1'b1;
      for (int i = 0; i < ns; i++) begin
        hi = (u >= 0 && acc[i] > u) ? u : acc[i];
        if (cyc >= offer[i] - 1 && cyc < hi) begin
          byte_if.byte_valid = 1'b1;
          byte_if.byte_data  = pkt_data[i];
          byte_if.byte_last  = (i == n - 1);
        end
      end
      step();

      e_load  = 1'b0;
      e_shift = 1'b0;
      for (int j = 0; j < nl; j++) begin
        k = cyc - load_at[j];
        if (k == 0) begin
          e_load  = 1'b1;
          exp_pts = pkt_data[j];
          $display("pkt %0d byte %0d data=%02h loaded at cycle %0d", pkt_id, j, pkt_data[j], cyc);
        end
        if (k >= C && k <= 7 * C && (k % C) == 0) e_shift = 1'b1;
        if (k >= 1 && k <= BYTE_T)
          check_eq("serial", 32'(pts_sr[0]), 32'(pkt_data[j][(k - 1) / C]));
      end
      e_ready = (cyc >= t0 && cyc < acc[0]);
      for (int i = 1; i < ns; i++) begin
        hi = (u >= 0 && acc[i] > u) ? u : acc[i];
        if (cyc >= load_at[i-1] && cyc < hi) e_ready = 1'b1;
      end

      check_eq("load",  32'(load_enable),        32'(e_load));
      check_eq("shift", 32'(shift_enable),       32'(e_shift));
      check_eq("excl",  32'(load_enable & shift_enable), 32'd0);
      check_eq("done",  32'(tx_done),            32'(completed && cyc == end_busy));
      check_eq("under", 32'(underrun),           32'(!completed && cyc == u));
      check_eq("busy",  32'(busy),               32'(cyc > t0 && cyc <= end_busy));
      check_eq("ready", 32'(byte_if.byte_ready), 32'(e_ready));
      check_eq("pts",   32'(pts_data),           32'(exp_pts));

      if (do_abort && cyc == abort_c) aborted = 1'b1;
    end

    tx_start           = 1'b0;
    byte_if.byte_valid = 1'b0;
    was_underrun = !completed && !aborted;
    if (aborted)        result = "reset";
    else if (completed) result = "done";
    else                result = "underrun";
    $display("pkt %0d: bytes=%0d loaded=%0d result=%s at cycle %0d", pkt_id, n, nl, result, cyc);
    pkt_id++;
    if (aborted || !completed) apply_reset();
  endtask

  initial begin
    bit ur;
    int n;
    int r;

    byte_if.byte_valid = 1'b0;
    byte_if.byte_data  = 8'h00;
    byte_if.byte_last  = 1'b0;
    apply_reset();
    idle_cycles(4);

    pkt_data[0] = 8'hA5; pkt_gap[0] = 0;
    run_packet(1, 1'b0, 1'b0, 1'b0, ur);
    idle_cycles(3);

    pkt_data[0] = 8'h3C; pkt_data[1] = 8'hC3; pkt_gap[0] = 1; pkt_gap[1] = 0;
    run_packet(2, 1'b0, 1'b0, 1'b0, ur);
    idle_cycles(3);

    pkt_data[0] = 8'h5A; pkt_data[1] = 8'h96; pkt_gap[0] = 2; pkt_gap[1] = 500;
    run_packet(2, 1'b0, 1'b0, 1'b0, ur);
    idle_cycles(3);

    pkt_gap[1] = -1;
    run_packet(2, 1'b0, 1'b0, 1'b0, ur);
    idle_cycles(3);

    pkt_data[2] = 8'h0F; pkt_gap[1] = -2; pkt_gap[2] = 3;
    run_packet(3, 1'b0, 1'b0, 1'b0, ur);
    idle_cycles(3);

    pkt_data[0] = 8'hE1; pkt_data[1] = 8'h7E; pkt_data[2] = 8'h42;
    pkt_gap[0] = 0; pkt_gap[1] = 0; pkt_gap[2] = 0;
    run_packet(3, 1'b1, 1'b0, 1'b0, ur);
    idle_cycles(12);

    run_packet(2, 1'b0, 1'b1, 1'b0, ur);
    idle_cycles(2);

    pkt_data[3] = 8'h81; pkt_gap[3] = 0;
    run_packet(4, 1'b0, 1'b0, 1'b1, ur);
    idle_cycles(2);

    for (int p = 0; p < 24; p++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        pkt_data[i] = 8'($urandom);
        r = int'($urandom_range(0, 19));
        if (i == 0)      pkt_gap[i] = int'($urandom_range(0, 4));
        else if (r == 0) pkt_gap[i] = -1;
        else if (r == 1) pkt_gap[i] = -2;
        else if (r < 15) pkt_gap[i] = int'($urandom_range(0, 20));
        else             pkt_gap[i] = int'($urandom_range(0, 90));
      end
      run_packet(n, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ur);
      idle_cycles(int'($urandom_range(1, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_shift_ctrl.md
# usb_tx_shift_ctrl

Sequencing controller for the USB transmit parallel-to-serial shift register (8 bits, LSB-first). It accepts bytes from the packet/encryption pipeline over a valid/ready handshake and holds one byte in a holding register. It drives the shift register's load and shift strobes at a fixed bit rate, so consecutive bytes go out with no gap bit. It also reports completion and underrun to the packet FSM.

## Interface
- CLKS_PER_BIT, 8: clk cycles per serial bit time; legal range ≥ 2.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  single-cycle pulse that begins a packet; honoured only in IDLE.
- byte_valid  in  1  byte_data and byte_last are valid.
- byte_data  in  8  next byte to transmit.
- byte_last  in  1  marks the final byte of the packet.
- byte_ready  out  1  controller accepts a byte this cycle.
- load_enable  out  1  one-cycle strobe; shift register loads pts_data.
- shift_enable  out  1  one-cycle strobe; shift register advances one bit.
- pts_data  out  8  byte presented for loading; registered.
- busy  out  1  high whenever state ≠ IDLE.
- tx_done  out  1  one-cycle pulse after the last bit time of the last byte.
- underrun  out  1  one-cycle pulse when a byte boundary arrives with the holding register empty.

## Operation
- **Handshake:** a transfer occurs when byte_valid && byte_ready at a rising edge. byte_data and byte_last are captured into hold_data and hold_last, and hold_full is set.
- **byte_ready** = (state ∈ {PRIME, SEND}) && !hold_full && !last_accepted. last_accepted is set by any transfer with byte_last=1.
- **IDLE:** all strobes are 0. tx_start → PRIME. Otherwise stay.
- **PRIME:** wait for the first byte. With hold_full=1, assert load_enable with pts_data=hold_data for one cycle, clear hold_full, set cur_last=hold_last, then → SEND with timer=0 and bit_cnt=0.
- **SEND:** timer counts 0..CLKS_PER_BIT-1 and wraps. At timer==CLKS_PER_BIT-1 (the bit boundary):
  - bit_cnt < 7: shift_enable=1, bit_cnt++.
  - bit_cnt==7 && !cur_last && hold_full: load_enable=1 (replaces the shift), pts_data=hold_data, clear hold_full, cur_last=hold_last, bit_cnt=0.
  - bit_cnt==7 && cur_last: → DONE.
  - bit_cnt==7 && !cur_last && !hold_full: underrun=1, → IDLE.
- **DONE:** tx_done=1 for one cycle, → IDLE. last_accepted is cleared on entry to IDLE.
- **Mutual exclusion:** load_enable and shift_enable are never high in the same cycle.
- **Simultaneous events:**
  - A transfer in the same cycle as a boundary load is not seen by that load. The held byte is loaded, and the new byte fills the holding register at the same edge.
  - A transfer arriving exactly at the bit_cnt==7 boundary with an empty holding register is too late: underrun.
- **Ignored inputs:** tx_start outside IDLE is ignored. Bytes offered while byte_ready=0 are not consumed.
- **Widths:** timer is $clog2(CLKS_PER_BIT) bits; bit_cnt is 3 bits and wraps only via load.

## Timing
- **Reset:** state=IDLE; byte_ready, load_enable, shift_enable, busy, tx_done, underrun = 0; pts_data=8'h00; hold_full=0. Reset mid-packet aborts immediately, with no tx_done and no underrun.
- **First load:** tx_start at edge t0 → PRIME from t0; byte_ready is high from the cycle after t0. Handshake at edge k → load_enable high in cycle k+1.
- **Per byte:** let L be the load cycle. shift_enable pulses at L+CLKS_PER_BIT·n for n=1..7. The next load, DONE entry or underrun occurs at L+8·CLKS_PER_BIT.
- **DONE / underrun:**
  - tx_done is high in cycle L+8·CLKS_PER_BIT+1.
  - After tx_done, busy falls one cycle later.
  - On underrun, busy falls in the cycle after the underrun pulse.
- **Throughput:** exactly one byte per 8·CLKS_PER_BIT cycles, with no idle bit time between bytes.

## Structure
- Package usb_tx_pkg holds:
  - typedef enum tx_ctrl_state_t {IDLE, PRIME, SEND, DONE};
  - localparam BYTE_BITS=8.
- Sub-module usb_bit_timer holds the modulo-CLKS_PER_BIT counter. It has a synchronous clear input and a one-cycle rollover pulse output.
- The shift register itself is instantiated by the parent, not inside this block.

## Test plan
- **Single byte:** CLKS_PER_BIT=8; tx_start; byte 8'hA5 with last=1, handshake at k.
  - load at k+1; shift pulses at k+9, k+17, …, k+57 (7 pulses); tx_done at k+66; busy low from k+67.
  - A PTS model's serial output is 1,0,1,0,0,1,0,1, 8 cycles each.
- **Back-to-back:** bytes 8'h3C, then 8'hC3 with last=1, second byte offered immediately.
  - second load exactly 64 cycles after the first; 14 shift pulses total; one tx_done; no underrun.
- **Underrun:** first byte with last=0, second byte withheld.
  - underrun pulses 64 cycles after the load; no tx_done; busy drops the next cycle.
- **Reset mid-packet:** n_rst low at bit 3 of byte 1.
  - all outputs go to 0 immediately, pts_data=00; after release the controller remains IDLE with no tx_done.
- **Ignored start:** tx_start pulsed while in SEND.
  - no effect on timing or count.
- **Back-pressure:** byte_valid held high the whole packet.
  - byte_ready drops when the holding register is full and after byte_last is accepted; no byte is accepted twice.
